pc_fetch_unit: RTL and testbench

// - Holds the program counter and drives instruction fetch from instruction memory.
// - Sits directly upstream of adderaddress:
//   - pc_out feeds adderaddress.preInstruction.
//   - adderaddress.nextInstruction returns on pc_plus.
// - Selects the next PC from sequential, branch and jump sources.
// - Runs a request/ready handshake with instruction memory.
// - Presents {instr_out, instr_pc, instr_valid} to decode; supports stall and flush.

---
 rtl/pc_fetch_unit_pkg.sv | 19 +
 rtl/pc_fetch_unit_next_sel.sv | 33 +++
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 tb/tb_pc_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the PC fetch unit: FSM state encoding and address/instruction widths.
// No logic lives here; latency and backpressure belong to the modules that import it.
package pc_fetch_unit_pkg;

    localparam int          ADDR_W_DEF   = 16;
    localparam int          INSTR_W_DEF  = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2
    } fetch_state_t;

    function automatic logic is_redirect(input logic jump, input logic branch_taken);
        return jump | branch_taken;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_sel.sv
// Next-PC priority mux (jump > branch > sequential) with the branch adder; purely combinational.
// Zero latency, no flow control; o_redirect flags a non-sequential target.
module pc_next_sel
    import pc_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] i_pc_plus,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_offset,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_target,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_redirect
);

    logic [ADDR_W-1:0] w_branch_target;

    // Plain ADDR_W-bit add: wraps modulo 2^ADDR_W by construction.
    assign w_branch_target = i_pc_plus + i_branch_offset;

    always_comb begin
        o_next_pc = i_pc_plus;
        if (i_jump) begin
            o_next_pc = i_jump_target;
        end else if (i_branch_taken) begin
            o_next_pc = w_branch_target;
        end
    end

    assign o_redirect = is_redirect(i_jump, i_branch_taken);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter plus instruction-fetch FSM with stall and redirect (flush) handling.
// One instruction per imem_ready; stall freezes fetch and drops same-cycle data; redirect beats stall.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic [ADDR_W-1:0]  pc_plus,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_offset,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_imem_req;
    logic [INSTR_W-1:0] r_instr_out;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               r_instr_valid;

    logic [ADDR_W-1:0]  w_next_pc;
    logic               w_redirect;

    pc_next_sel #(.ADDR_W(ADDR_W)) u_next_sel (
        .i_pc_plus       (pc_plus),
        .i_branch_taken  (branch_taken),
        .i_branch_offset (branch_offset),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .o_next_pc       (w_next_pc),
        .o_redirect      (w_redirect)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_instr_out   <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (w_redirect) begin
            // Flush: abandon any in-flight fetch and ignore stall and same-cycle ready.
            r_state       <= S_FETCH;
            r_pc          <= w_next_pc;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (stall) begin
                        r_state    <= S_STALL;
                        r_imem_req <= 1'b0;
                    end else if (imem_ready) begin
                        r_instr_out   <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_pc          <= w_next_pc;
                    end else begin
                        r_instr_valid <= 1'b0;
                    end
                end
                S_STALL: begin
                    // Decode takes the held instruction on the release cycle, so it is not re-presented.
                    if (!stall) begin
                        r_state       <= S_FETCH;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_BOOT;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out      = r_pc;
    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_out   = r_instr_out;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] pc_out;
    logic [15:0] pc_plus;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [15:0] jump_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;

    int total = 0;
    int bad   = 0;

    // Model of what the fetch unit has promised to decode and memory.
    logic [15:0] m_pc;
    logic        m_fetching;
    logic        m_booting;
    logic        m_valid;
    logic [15:0] m_out;
    logic [15:0] m_ipc;

    pc_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc_out        (pc_out),
        .pc_plus       (pc_plus),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid)
    );

    // External adderaddress stand-in.
    assign pc_plus = pc_out + 16'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, then compare every output to it.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [15:0] off,
                       input logic j, input logic [15:0] jt, input logic rdy);
        logic [15:0] data;
        data          = 16'($urandom);
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_offset = off;
        jump          = j;
        jump_target   = jt;
        imem_ready    = rdy;
        imem_rdata    = data;

        if (r) begin
            m_pc = 16'h0000; m_booting = 1'b1; m_fetching = 1'b0;
            m_valid = 1'b0; m_out = 16'h0000; m_ipc = 16'h0000;
        end else if (j || b) begin
            m_pc       = j ? jt : m_pc + 16'd1 + off;
            m_valid    = 1'b0;
            m_booting  = 1'b0;
            m_fetching = 1'b1;
        end else if (m_booting) begin
            m_booting  = 1'b0;
            m_fetching = 1'b1;
        end else if (!m_fetching) begin
            if (!s) begin
                m_fetching = 1'b1;
                m_valid    = 1'b0;
            end
        end else if (s) begin
            m_fetching = 1'b0;
        end else if (rdy) begin
            m_out   = data;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
        end else begin
            m_valid = 1'b0;
        end

        @(posedge clk);
        #1;
        total++;
        if (imem_req !== m_fetching) begin
            bad++; $display("FAIL model_req: got %b want %b at t=%0t", imem_req, m_fetching, $time);
        end
        total++;
        if (pc_out !== m_pc) begin
            bad++; $display("FAIL model_pc: got %h want %h at t=%0t", pc_out, m_pc, $time);
        end
        if (m_fetching) begin
            total++;
            if (imem_addr !== m_pc) begin
                bad++; $display("FAIL model_addr: got %h want %h at t=%0t", imem_addr, m_pc, $time);
            end
        end
        total++;
        if (instr_valid !== m_valid || instr_out !== m_out || instr_pc !== m_ipc) begin
            bad++;
            $display("FAIL model_instr: got v=%b d=%h pc=%h want v=%b d=%h pc=%h at t=%0t",
                     instr_valid, instr_out, instr_pc, m_valid, m_out, m_ipc, $time);
        end
    endtask

    task automatic idle(input logic s, input logic rdy);
        cyc(1'b0, s, 1'b0, 16'h0, 1'b0, 16'h0, rdy);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 16'h7, 1'b1, 16'h1234, 1'b1);
        total++;
        if (pc_out !== 16'h0000 || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 16'h0) begin
            bad++;
            $display("FAIL reset: got pc=%h req=%b v=%b d=%h want 0000 0 0 0000", pc_out, imem_req, instr_valid, instr_out);
        end
    endtask

    task automatic test_seq();
        idle(1'b0, 1'b1);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            bad++; $display("FAIL seq_first: got req=%b addr=%h want 1 0000", imem_req, imem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            idle(1'b0, 1'b1);
            total++;
            if (imem_addr !== 16'(k) || instr_valid !== 1'b1 || instr_pc !== 16'(k - 1)) begin
                bad++;
                $display("FAIL seq_step%0d: got addr=%h v=%b ipc=%h want %h 1 %h", k, imem_addr, instr_valid, instr_pc, 16'(k), 16'(k - 1));
            end
        end
    endtask

    task automatic test_wait();
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0, 1'b0);
            total++;
            if (imem_addr !== 16'h0005 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
                bad++; $display("FAIL wait_hold: got addr=%h v=%b want 0005 0", imem_addr, instr_valid);
            end
        end
        idle(1'b0, 1'b1);
        total++;
        if (imem_addr !== 16'h0006 || instr_pc !== 16'h0005) begin
            bad++; $display("FAIL wait_release: got addr=%h ipc=%h want 0006 0005", imem_addr, instr_pc);
        end
    endtask

    task automatic test_stall();
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ready = 1'b1;
        imem_rdata = 16'hABCD;
        @(posedge clk);
        #1;
        m_out = 16'hABCD; m_ipc = 16'h0006; m_valid = 1'b1; m_pc = 16'h0007;
        total++;
        if (instr_out !== 16'hABCD || instr_pc !== 16'h0006) begin
            bad++; $display("FAIL stall_load: got d=%h ipc=%h want abcd 0006", instr_out, instr_pc);
        end
        for (int k = 0; k < 2; k++) begin
            idle(1'b1, 1'b1);
            total++;
            if (instr_out !== 16'hABCD || instr_pc !== 16'h0006 || instr_valid !== 1'b1
                || imem_req !== 1'b0 || pc_out !== 16'h0007) begin
                bad++;
                $display("FAIL stall_hold: got d=%h ipc=%h v=%b req=%b pc=%h want abcd 0006 1 0 0007",
                         instr_out, instr_pc, instr_valid, imem_req, pc_out);
            end
        end
        idle(1'b0, 1'b1);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0007) begin
            bad++; $display("FAIL stall_resume: got req=%b addr=%h want 1 0007", imem_req, imem_addr);
        end
        idle(1'b0, 1'b1);
    endtask

    task automatic test_branch();
        total++;
        if (pc_out !== 16'h0008) begin
            bad++; $display("FAIL branch_setup: got pc=%h want 0008", pc_out);
        end
        cyc(1'b0, 1'b0, 1'b1, 16'hFFFC, 1'b0, 16'h0, 1'b1);
        total++;
        if (imem_addr !== 16'h0005 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL branch_target: got addr=%h v=%b want 0005 0", imem_addr, instr_valid);
        end
        cyc(1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1);
        total++;
        if (imem_addr !== 16'h0040) begin
            bad++; $display("FAIL jump_priority: got addr=%h want 0040", imem_addr);
        end
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0100, 1'b1);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
            bad++; $display("FAIL redirect_over_stall: got req=%b addr=%h want 1 0100", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b0);
        idle(1'b0, 1'b1);
        total++;
        if (imem_addr !== 16'h0000 || instr_pc !== 16'hFFFF) begin
            bad++; $display("FAIL wrap_seq: got addr=%h ipc=%h want 0000 ffff", imem_addr, instr_pc);
        end
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFD, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0, 1'b1);
        total++;
        if (imem_addr !== 16'h0002) begin
            bad++; $display("FAIL wrap_branch: got addr=%h want 0002", imem_addr);
        end
    endtask

    task automatic test_mid_reset();
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        total++;
        if (pc_out !== 16'h0000 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got pc=%h req=%b v=%b want 0000 0 0", pc_out, imem_req, instr_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
                16'($urandom), $urandom_range(0, 99) < 5, 16'($urandom), $urandom_range(0, 99) < 60);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
        jump = 1'b0; jump_target = 16'h0; imem_ready = 1'b0; imem_rdata = 16'h0;
        m_pc = 16'h0; m_fetching = 1'b0; m_booting = 1'b1; m_valid = 1'b0;
        m_out = 16'h0; m_ipc = 16'h0;
        test_reset();
        test_seq();
        test_wait();
        test_stall();
        test_branch();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
